// File: rtl/mem_lsu_pkg.sv
// ============================================================================
//  Module   : mem_lsu_pkg
//  Purpose  : Shared definitions for the bittyCore memory-access stage.
//             Holds the bus widths, the EXE_MEM_* memory-op encodings, the
//             LSU state encoding and small op-classification helpers.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_lsu_pkg;

   localparam int REG_BUS      = 32;
   localparam int REG_ADDR_BUS = 5;
   localparam int MEM_OP_BUS   = 4;

   localparam logic [MEM_OP_BUS-1:0] EXE_MEM_NOP = 4'd0;
   localparam logic [MEM_OP_BUS-1:0] EXE_MEM_LB  = 4'd1;
   localparam logic [MEM_OP_BUS-1:0] EXE_MEM_LH  = 4'd2;
   localparam logic [MEM_OP_BUS-1:0] EXE_MEM_LW  = 4'd3;
   localparam logic [MEM_OP_BUS-1:0] EXE_MEM_LBU = 4'd4;
   localparam logic [MEM_OP_BUS-1:0] EXE_MEM_LHU = 4'd5;
   localparam logic [MEM_OP_BUS-1:0] EXE_MEM_SB  = 4'd6;
   localparam logic [MEM_OP_BUS-1:0] EXE_MEM_SH  = 4'd7;
   localparam logic [MEM_OP_BUS-1:0] EXE_MEM_SW  = 4'd8;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_RESP = 2'd2
   } lsu_state_e;

   function automatic logic is_load(input logic [MEM_OP_BUS-1:0] op);
      return (op == EXE_MEM_LB)  || (op == EXE_MEM_LH)  || (op == EXE_MEM_LW) ||
             (op == EXE_MEM_LBU) || (op == EXE_MEM_LHU);
   endfunction

   function automatic logic is_store(input logic [MEM_OP_BUS-1:0] op);
      return (op == EXE_MEM_SB) || (op == EXE_MEM_SH) || (op == EXE_MEM_SW);
   endfunction

   // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
   function automatic logic is_misaligned(input logic [MEM_OP_BUS-1:0] op,
                                          input logic [1:0]            a);
      if (op == EXE_MEM_LH || op == EXE_MEM_LHU || op == EXE_MEM_SH)
         return a[0];
      if (op == EXE_MEM_LW || op == EXE_MEM_SW)
         return (a != 2'b00);
      return 1'b0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Purely combinational byte-lane alignment for the LSU.
//  Ports    : op_i       memory op (EXE_MEM_*)
//             addr_lo_i  byte offset within the word
//             sdata_i    raw store data
//             rdata_i    raw read word from the bus
//             be_o       byte enables for the access
//             wdata_o    lane-replicated store data
//             ldata_o    extracted, extended load result
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_align
   import mem_lsu_pkg::*;
(
   input  logic [MEM_OP_BUS-1:0] op_i,
   input  logic [1:0]            addr_lo_i,
   input  logic [REG_BUS-1:0]    sdata_i,
   input  logic [REG_BUS-1:0]    rdata_i,
   output logic [3:0]            be_o,
   output logic [REG_BUS-1:0]    wdata_o,
   output logic [REG_BUS-1:0]    ldata_o
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   always_comb begin
      case (addr_lo_i)
         2'd0:    rbyte = rdata_i[7:0];
         2'd1:    rbyte = rdata_i[15:8];
         2'd2:    rbyte = rdata_i[23:16];
         default: rbyte = rdata_i[31:24];
      endcase
      rhalf = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      be_o    = 4'b0000;
      wdata_o = '0;
      ldata_o = '0;
      case (op_i)
         EXE_MEM_LB:  begin be_o = 4'b0001 << addr_lo_i;               ldata_o = {{24{rbyte[7]}}, rbyte};  end
         EXE_MEM_LBU: begin be_o = 4'b0001 << addr_lo_i;               ldata_o = {24'h0, rbyte};           end
         EXE_MEM_LH:  begin be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;   ldata_o = {{16{rhalf[15]}}, rhalf}; end
         EXE_MEM_LHU: begin be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;   ldata_o = {16'h0, rhalf};           end
         EXE_MEM_LW:  begin be_o = 4'b1111;                            ldata_o = rdata_i;                  end
         EXE_MEM_SB:  begin be_o = 4'b0001 << addr_lo_i;               wdata_o = {4{sdata_i[7:0]}};        end
         EXE_MEM_SH:  begin be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;   wdata_o = {2{sdata_i[15:0]}};       end
         EXE_MEM_SW:  begin be_o = 4'b1111;                            wdata_o = sdata_i;                  end
         default:     begin end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
// ============================================================================
//  Module   : mem_lsu
//  Purpose  : bittyCore memory-access stage. Non-memory results pass through
//             one register; loads/stores run over a req/gnt/rvalid bus and
//             the result is registered toward writeback.
//  Ports    : clk, rst (sync, active-high)
//             in_valid_i/in_ready_o, memop_i, wd_i, wreg_i, wdata_i,
//             mem_addr_i, mem_sdata_i                 - from execute
//             dbus_req_o/we_o/addr_o/be_o/wdata_o,
//             dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i - data bus
//             out_valid_o, wd_o, wreg_o, wdata_o      - to writeback
//             misalign_o                              - only with trap build
//  Config   : MEM_MISALIGN_TRAP_EN adds misalignment trapping and misalign_o.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_lsu
   import mem_lsu_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [MEM_OP_BUS-1:0]   memop_i,
   input  logic [REG_ADDR_BUS-1:0] wd_i,
   input  logic                    wreg_i,
   input  logic [REG_BUS-1:0]      wdata_i,
   input  logic [REG_BUS-1:0]      mem_addr_i,
   input  logic [REG_BUS-1:0]      mem_sdata_i,
   output logic                    dbus_req_o,
   output logic                    dbus_we_o,
   output logic [REG_BUS-1:0]      dbus_addr_o,
   output logic [3:0]              dbus_be_o,
   output logic [REG_BUS-1:0]      dbus_wdata_o,
   input  logic                    dbus_gnt_i,
   input  logic                    dbus_rvalid_i,
   input  logic [REG_BUS-1:0]      dbus_rdata_i,
   output logic                    out_valid_o,
   output logic [REG_ADDR_BUS-1:0] wd_o,
   output logic                    wreg_o,
   output logic [REG_BUS-1:0]      wdata_o
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic                    misalign_o
`endif
);

   lsu_state_e state_q, state_d;

   logic [MEM_OP_BUS-1:0]   op_q;
   logic [REG_BUS-1:0]      addr_q;
   logic [REG_BUS-1:0]      sdata_q;
   logic [REG_ADDR_BUS-1:0] wd_q;
   logic                    wreg_q;
   logic                    accept_mem;

   logic                    out_valid_q, out_valid_d;
   logic [REG_ADDR_BUS-1:0] wd_out_q,    wd_out_d;
   logic                    wreg_out_q,  wreg_out_d;
   logic [REG_BUS-1:0]      wdata_out_q, wdata_out_d;
`ifdef MEM_MISALIGN_TRAP_EN
   logic                    misalign_q,  misalign_d;
`endif

   logic [REG_BUS-1:0]      load_result;

   // Alignment works from the latched request, so bus lanes stay stable
   // for the whole REQ phase regardless of what execute is presenting.
   lsu_align u_align (
      .op_i      (op_q),
      .addr_lo_i (addr_q[1:0]),
      .sdata_i   (sdata_q),
      .rdata_i   (dbus_rdata_i),
      .be_o      (dbus_be_o),
      .wdata_o   (dbus_wdata_o),
      .ldata_o   (load_result)
   );

   always_comb begin
      state_d     = state_q;
      accept_mem  = 1'b0;
      out_valid_d = 1'b0;
      wd_out_d    = wd_out_q;
      wreg_out_d  = wreg_out_q;
      wdata_out_d = wdata_out_q;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_d  = 1'b0;
`endif
      case (state_q)
         LSU_IDLE: begin
            if (in_valid_i) begin
               // Unknown op codes are treated like NOP (plain pass-through).
               if (!is_load(memop_i) && !is_store(memop_i)) begin
                  out_valid_d = 1'b1;
                  wd_out_d    = wd_i;
                  wreg_out_d  = wreg_i;
                  wdata_out_d = wdata_i;
               end
`ifdef MEM_MISALIGN_TRAP_EN
               else if (is_misaligned(memop_i, mem_addr_i[1:0])) begin
                  out_valid_d = 1'b1;
                  wd_out_d    = wd_i;
                  wreg_out_d  = 1'b0;
                  wdata_out_d = '0;
                  misalign_d  = 1'b1;
               end
`endif
               else begin
                  accept_mem = 1'b1;
                  state_d    = LSU_REQ;
               end
            end
         end
         LSU_REQ: begin
            if (dbus_gnt_i) begin
               if (is_store(op_q)) begin
                  state_d     = LSU_IDLE;
                  out_valid_d = 1'b1;
                  wd_out_d    = wd_q;
                  wreg_out_d  = 1'b0;
                  wdata_out_d = '0;
               end else begin
                  state_d = LSU_RESP;
               end
            end
         end
         LSU_RESP: begin
            if (dbus_rvalid_i) begin
               state_d     = LSU_IDLE;
               out_valid_d = 1'b1;
               wd_out_d    = wd_q;
               wreg_out_d  = wreg_q;
               wdata_out_d = load_result;
            end
         end
         default: state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= LSU_IDLE;
         op_q        <= EXE_MEM_NOP;
         addr_q      <= '0;
         sdata_q     <= '0;
         wd_q        <= '0;
         wreg_q      <= 1'b0;
         out_valid_q <= 1'b0;
         wd_out_q    <= '0;
         wreg_out_q  <= 1'b0;
         wdata_out_q <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         wd_out_q    <= wd_out_d;
         wreg_out_q  <= wreg_out_d;
         wdata_out_q <= wdata_out_d;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_q  <= misalign_d;
`endif
         if (accept_mem) begin
            op_q    <= memop_i;
            addr_q  <= mem_addr_i;
            sdata_q <= mem_sdata_i;
            wd_q    <= wd_i;
            wreg_q  <= wreg_i;
         end
      end
   end

   assign in_ready_o  = (state_q == LSU_IDLE);
   assign dbus_req_o  = (state_q == LSU_REQ);
   assign dbus_we_o   = (state_q == LSU_REQ) && is_store(op_q);
   assign dbus_addr_o = {addr_q[REG_BUS-1:2], 2'b00};

   assign out_valid_o = out_valid_q;
   assign wd_o        = wd_out_q;
   assign wreg_o      = wreg_out_q;
   assign wdata_o     = wdata_out_q;
`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign_o  = misalign_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ============================================================================
//  Module   : tb_mem_lsu
//  Purpose  : Directed self-checking bench for mem_lsu.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_lsu;
   import mem_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [3:0]  memop_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] wdata_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_sdata_i;
   logic        dbus_req_o;
   logic        dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [3:0]  dbus_be_o;
   logic [31:0] dbus_wdata_o;
   logic        dbus_gnt_i;
   logic        dbus_rvalid_i;
   logic [31:0] dbus_rdata_i;
   logic        out_valid_o;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign_o;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_lsu dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .memop_i       (memop_i),
      .wd_i          (wd_i),
      .wreg_i        (wreg_i),
      .wdata_i       (wdata_i),
      .mem_addr_i    (mem_addr_i),
      .mem_sdata_i   (mem_sdata_i),
      .dbus_req_o    (dbus_req_o),
      .dbus_we_o     (dbus_we_o),
      .dbus_addr_o   (dbus_addr_o),
      .dbus_be_o     (dbus_be_o),
      .dbus_wdata_o  (dbus_wdata_o),
      .dbus_gnt_i    (dbus_gnt_i),
      .dbus_rvalid_i (dbus_rvalid_i),
      .dbus_rdata_i  (dbus_rdata_i),
      .out_valid_o   (out_valid_o),
      .wd_o          (wd_o),
      .wreg_o        (wreg_o),
      .wdata_o       (wdata_o)
`ifdef MEM_MISALIGN_TRAP_EN
      ,
      .misalign_o    (misalign_o)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_op(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                           input logic [31:0] wdata, input logic [31:0] addr,
                           input logic [31:0] sdata);
      in_valid_i  = 1'b1;
      memop_i     = op;
      wd_i        = wd;
      wreg_i      = wreg;
      wdata_i     = wdata;
      mem_addr_i  = addr;
      mem_sdata_i = sdata;
   endtask

   initial begin
      rst = 1'b1;
      in_valid_i = 1'b0; memop_i = EXE_MEM_NOP; wd_i = '0; wreg_i = 1'b0;
      wdata_i = '0; mem_addr_i = '0; mem_sdata_i = '0;
      dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = '0;
      @(negedge clk);
      step();
      rst = 1'b0;
      step();

      // Reset state
      chk("rst_ready",  {31'b0, in_ready_o},  32'd1);
      chk("rst_req",    {31'b0, dbus_req_o},  32'd0);
      chk("rst_we",     {31'b0, dbus_we_o},   32'd0);
      chk("rst_be",     {28'b0, dbus_be_o},   32'd0);
      chk("rst_addr",   dbus_addr_o,          32'd0);
      chk("rst_ovalid", {31'b0, out_valid_o}, 32'd0);
      chk("rst_wdata",  wdata_o,              32'd0);

      // Non-memory ops, back to back
      drive_op(EXE_MEM_NOP, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0);
      step();
      chk("nop1_valid", {31'b0, out_valid_o}, 32'd1);
      chk("nop1_wd",    {27'b0, wd_o},        32'd5);
      chk("nop1_wreg",  {31'b0, wreg_o},      32'd1);
      chk("nop1_wdata", wdata_o,              32'h1234);
      drive_op(EXE_MEM_NOP, 5'd7, 1'b1, 32'h55, 32'h0, 32'h0);
      step();
      chk("nop2_valid", {31'b0, out_valid_o}, 32'd1);
      chk("nop2_wdata", wdata_o,              32'h55);
      in_valid_i = 1'b0;
      step();
      chk("nop_idle_valid", {31'b0, out_valid_o}, 32'd0);

      // SB with immediate grant
      drive_op(EXE_MEM_SB, 5'd9, 1'b1, 32'hDEAD, 32'h1003, 32'hAB);
      step();
      in_valid_i = 1'b0;
      chk("sb_req",   {31'b0, dbus_req_o}, 32'd1);
      chk("sb_we",    {31'b0, dbus_we_o},  32'd1);
      chk("sb_ready", {31'b0, in_ready_o}, 32'd0);
      chk("sb_addr",  dbus_addr_o,         32'h1000);
      chk("sb_be",    {28'b0, dbus_be_o},  32'h8);
      chk("sb_wdata", dbus_wdata_o,        32'hABABABAB);
      chk("sb_noval", {31'b0, out_valid_o}, 32'd0);
      dbus_gnt_i = 1'b1;
      step();
      dbus_gnt_i = 1'b0;
      chk("sb_valid", {31'b0, out_valid_o}, 32'd1);
      chk("sb_wreg",  {31'b0, wreg_o},      32'd0);
      chk("sb_wdo",   wdata_o,              32'd0);
      chk("sb_reqlo", {31'b0, dbus_req_o},  32'd0);

      // SH and SW lane checks
      drive_op(EXE_MEM_SH, 5'd1, 1'b0, 32'h0, 32'h2002, 32'hFFFF1234);
      step();
      in_valid_i = 1'b0;
      chk("sh_be",    {28'b0, dbus_be_o}, 32'hC);
      chk("sh_wdata", dbus_wdata_o,       32'h12341234);
      dbus_gnt_i = 1'b1;
      step();
      dbus_gnt_i = 1'b0;
      drive_op(EXE_MEM_SW, 5'd1, 1'b0, 32'h0, 32'h3004, 32'hCAFEF00D);
      step();
      in_valid_i = 1'b0;
      chk("sw_be",    {28'b0, dbus_be_o}, 32'hF);
      chk("sw_wdata", dbus_wdata_o,       32'hCAFEF00D);
      chk("sw_addr",  dbus_addr_o,        32'h3004);
      dbus_gnt_i = 1'b1;
      step();
      dbus_gnt_i = 1'b0;

      // LB with grant delayed three cycles
      drive_op(EXE_MEM_LB, 5'd3, 1'b1, 32'h0, 32'h2001, 32'h0);
      step();
      in_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("lb_req_wait%0d", i), {31'b0, dbus_req_o}, 32'd1);
         step();
      end
      chk("lb_we",   {31'b0, dbus_we_o}, 32'd0);
      chk("lb_addr", dbus_addr_o,        32'h2000);
      dbus_gnt_i = 1'b1;
      step();
      dbus_gnt_i = 1'b0;
      chk("lb_resp_req", {31'b0, dbus_req_o}, 32'd0);
      dbus_rvalid_i = 1'b1;
      dbus_rdata_i  = 32'h000080FF;
      step();
      dbus_rvalid_i = 1'b0;
      chk("lb_valid", {31'b0, out_valid_o}, 32'd1);
      chk("lb_wreg",  {31'b0, wreg_o},      32'd1);
      chk("lb_wd",    {27'b0, wd_o},        32'd3);
      chk("lb_wdata", wdata_o,              32'hFFFFFF80);

      // LHU, immediate grant, in_ready low throughout
      drive_op(EXE_MEM_LHU, 5'd4, 1'b1, 32'h0, 32'h2002, 32'h0);
      step();
      in_valid_i = 1'b0;
      chk("lhu_ready_req", {31'b0, in_ready_o}, 32'd0);
      dbus_gnt_i = 1'b1;
      step();
      dbus_gnt_i = 1'b0;
      chk("lhu_ready_resp", {31'b0, in_ready_o}, 32'd0);
      dbus_rvalid_i = 1'b1;
      dbus_rdata_i  = 32'h80010000;
      step();
      dbus_rvalid_i = 1'b0;
      chk("lhu_valid", {31'b0, out_valid_o}, 32'd1);
      chk("lhu_wdata", wdata_o,              32'h00008001);
      chk("lhu_ready_done", {31'b0, in_ready_o}, 32'd1);

      // LH sign extension
      drive_op(EXE_MEM_LH, 5'd6, 1'b1, 32'h0, 32'h2000, 32'h0);
      step();
      in_valid_i = 1'b0;
      dbus_gnt_i = 1'b1;
      step();
      dbus_gnt_i = 1'b0;
      dbus_rvalid_i = 1'b1;
      dbus_rdata_i  = 32'h12349ABC;
      step();
      dbus_rvalid_i = 1'b0;
      chk("lh_wdata", wdata_o, 32'hFFFF9ABC);

      // Reset while in RESP aborts the load
      drive_op(EXE_MEM_LW, 5'd8, 1'b1, 32'h0, 32'h4000, 32'h0);
      step();
      in_valid_i = 1'b0;
      dbus_gnt_i = 1'b1;
      step();
      dbus_gnt_i = 1'b0;
      rst = 1'b1;
      dbus_rvalid_i = 1'b1;
      dbus_rdata_i  = 32'h11111111;
      step();
      chk("rstm_req",    {31'b0, dbus_req_o},  32'd0);
      chk("rstm_ovalid", {31'b0, out_valid_o}, 32'd0);
      rst = 1'b0;
      step();
      chk("rstm_ready",  {31'b0, in_ready_o},  32'd1);
      chk("rstm_drop",   {31'b0, out_valid_o}, 32'd0);
      dbus_rvalid_i = 1'b0;
      step();
      chk("rstm_drop2",  {31'b0, out_valid_o}, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
      drive_op(EXE_MEM_LW, 5'd2, 1'b1, 32'h0, 32'h3002, 32'h0);
      step();
      in_valid_i = 1'b0;
      chk("mis_req",    {31'b0, dbus_req_o},  32'd0);
      chk("mis_valid",  {31'b0, out_valid_o}, 32'd1);
      chk("mis_flag",   {31'b0, misalign_o},  32'd1);
      chk("mis_wreg",   {31'b0, wreg_o},      32'd0);
      chk("mis_ready",  {31'b0, in_ready_o},  32'd1);
      step();
      chk("mis_pulse",  {31'b0, misalign_o},  32'd0);
`else
      // Low address bits ignored: misaligned LW goes to the bus word-aligned
      drive_op(EXE_MEM_LW, 5'd2, 1'b1, 32'h0, 32'h3002, 32'h0);
      step();
      in_valid_i = 1'b0;
      chk("lwm_req",  {31'b0, dbus_req_o}, 32'd1);
      chk("lwm_addr", dbus_addr_o,         32'h3000);
      dbus_gnt_i = 1'b1;
      step();
      dbus_gnt_i = 1'b0;
      dbus_rvalid_i = 1'b1;
      dbus_rdata_i  = 32'hA5A55A5A;
      step();
      dbus_rvalid_i = 1'b0;
      chk("lwm_wdata", wdata_o, 32'hA5A55A5A);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_lsu.md
# mem_lsu

Memory-access stage of the bittyCore pipeline, directly downstream of the execute stage. It consumes execute results (destination register, write enable, ALU result) and optional load/store requests. Non-memory results pass through one register stage. Loads and stores are driven over a request/grant/rvalid data bus, with byte-lane alignment and load sign extension, and the result is registered toward writeback.

## Interface
- none — no parameters; widths come from shared defines: RegBus = 32, RegAddrBus = 5, MemOpBus = 4.
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid_i  in  1  execute result valid this cycle.
- in_ready_o  out  1  stage can accept; equals (state == IDLE).
- memop_i  in  4  EXE_MEM_NOP/LB/LH/LW/LBU/LHU/SB/SH/SW.
- wd_i  in  5  destination register address.
- wreg_i  in  1  destination write enable.
- wdata_i  in  32  ALU result; used for non-memory ops.
- mem_addr_i  in  32  effective byte address.
- mem_sdata_i  in  32  store data; low byte/half/word used.
- dbus_req_o  out  1  bus request; held until grant.
- dbus_we_o  out  1  1 = store.
- dbus_addr_o  out  32  word address {addr[31:2],2'b00}.
- dbus_be_o  out  4  byte enables.
- dbus_wdata_o  out  32  lane-replicated store data.
- dbus_gnt_i  in  1  request accepted this cycle.
- dbus_rvalid_i  in  1  read data valid; earliest one cycle after gnt.
- dbus_rdata_i  in  32  read word.
- out_valid_o  out  1  one-cycle pulse: result to writeback.
- wd_o  out  5, wreg_o  out  1, wdata_o  out  32  writeback result.
- misalign_o  out  1  present only with MEM_MISALIGN_TRAP_EN.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE with in_valid_i and memop NOP: next cycle out_valid_o=1, with wd/wreg/wdata copied from the inputs. Stay in IDLE.
- IDLE with in_valid_i and a memory op: latch op, address, data, and wd/wreg. Go to REQ.
- REQ: dbus_req_o=1, with addr/we/be/wdata taken from the latched values.
- REQ, store, gnt=1: go to IDLE. Next cycle out_valid_o=1, wreg_o=0, wdata_o=0.
- REQ, load, gnt=1: go to RESP.
- RESP, rvalid=1: go to IDLE. Next cycle out_valid_o=1 with the extracted load result. wreg_o is the latched wreg_i.
- Byte enables: SB → 4'b0001 << addr[1:0]. SH → addr[1] ? 4'b1100 : 4'b0011. SW → 4'b1111.
- Store data: SB → byte replicated ×4. SH → half replicated ×2. SW → word.
- Load extraction:
  - LB/LBU select byte addr[1:0].
  - LH/LHU select half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Without the macro, low address bits below the access size are ignored; there is no misalignment detection.
- dbus_* outputs are 0 outside REQ. Exception: dbus_addr/be/wdata may hold their values, but dbus_req_o must be 0.
- rvalid or gnt arriving in an unexpected state is ignored.

## Timing
- Reset: state IDLE. All outputs 0, except in_ready_o=1 in the cycle after reset is released.
- Reset mid-transaction aborts it: dbus_req_o=0 next cycle, no out_valid. An outstanding rvalid is dropped.
- Latency from the accept edge:
  - Non-memory op: 1 cycle.
  - Store with immediate grant: 2 cycles.
  - Load with immediate grant and rvalid one cycle later: 3 cycles.
- Back-to-back non-memory ops: 1 per cycle.
- Memory ops block input (in_ready_o=0) until the FSM returns to IDLE.
- out_valid_o is high exactly one cycle per accepted op. Writeback has no backpressure.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned access issues no bus request. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - The FSM stays in IDLE.
  - Next cycle: out_valid_o=1, wreg_o=0, misalign_o=1 (one-cycle pulse).
- MEM_MISALIGN_TRAP_EN undefined: the misalign_o port and its logic are absent, and low address bits are silently ignored.

## Structure
- bitty_defs.v gains:
  - the MemOpBus width;
  - the EXE_MEM_* op encodings;
  - the LSU state encodings.
- Sub-module lsu_align, purely combinational: (op, addr[1:0], sdata, rdata) → (be, wdata, load result).

## Test plan
- Non-memory op: wd=5, wreg=1, wdata=32'h1234 → next cycle out_valid_o=1, wd_o=5, wdata_o=32'h1234.
- SB addr=32'h1003, sdata=32'hAB, gnt on first REQ cycle:
  - dbus_addr_o=32'h1000, be=4'b1000, wdata=32'hABABABAB;
  - out_valid_o with wreg_o=0 at +2.
- LB addr=32'h2001, rdata=32'h0000_80FF, gnt delayed 3 cycles:
  - dbus_req_o held all 3 cycles;
  - wdata_o=32'hFFFF_FF80.
- LHU addr=32'h2002, rdata=32'h8001_0000 → wdata_o=32'h0000_8001. Also check in_ready_o=0 throughout.
- rst asserted while in RESP → dbus_req_o=0, no out_valid_o, in_ready_o=1 after reset.
- With MEM_MISALIGN_TRAP_EN, LW addr=32'h3002 → dbus_req_o stays 0; next cycle misalign_o=1, wreg_o=0.
